// File: rtl/stack_ctrl.sv
// LIFO stack controller driving a 16x4 registered-read memory.
// Serialises PUSH/POP/PEEK/CLEAR commands into single-cycle memory accesses and owns depth/full/empty.

`ifndef MEMORY_ADDR_BITS
`define MEMORY_ADDR_BITS 4
`endif
`ifndef MEMORY_MODE_IDLE
`define MEMORY_MODE_IDLE 2'b00
`endif
`ifndef MEMORY_MODE_READ
`define MEMORY_MODE_READ 2'b01
`endif
`ifndef MEMORY_MODE_WRITE
`define MEMORY_MODE_WRITE 2'b10
`endif
`ifndef MEMORY_MODE_CLEAR
`define MEMORY_MODE_CLEAR 2'b11
`endif

module stack_ctrl #(
  parameter int ADDR_BITS   = `MEMORY_ADDR_BITS,
  parameter int STACK_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [3:0]           cmd_data,
  output logic                 cmd_ready,
  output logic                 rsp_valid,
  output logic [3:0]           rsp_data,
  output logic                 rsp_err,
  output logic [ADDR_BITS:0]   depth,
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           mem_mode,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_data_in,
  input  logic [3:0]           mem_data_out
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] MODE_IDLE  = `MEMORY_MODE_IDLE;
  localparam logic [1:0] MODE_READ  = `MEMORY_MODE_READ;
  localparam logic [1:0] MODE_WRITE = `MEMORY_MODE_WRITE;
  localparam logic [1:0] MODE_CLEAR = `MEMORY_MODE_CLEAR;

  localparam logic [ADDR_BITS:0] DEPTH_MAX = (ADDR_BITS+1)'(STACK_DEPTH);
  localparam logic [ADDR_BITS:0] DEPTH_ONE = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0] DEPTH_ZERO = '0;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   depth_q, depth_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [3:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [1:0]           mem_mode_q, mem_mode_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]           mem_data_in_q, mem_data_in_d;
  logic [ADDR_BITS:0]   depth_dec;

  assign depth_dec = depth_q - DEPTH_ONE;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    mem_mode_d    = MODE_IDLE;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;

    case (state_q)
      ST_INIT: begin
        // mem_mode_q doubles as the "clear already issued" marker.
        if (mem_mode_q == MODE_CLEAR) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          mem_mode_d = MODE_CLEAR;
        end
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          case (cmd_op)
            OP_PUSH: begin
              if (full_q) begin
                state_d    = ST_RESP;
                rsp_err_d  = 1'b1;
                rsp_data_d = 4'h0;
              end else begin
                state_d       = ST_WRITE;
                mem_mode_d    = MODE_WRITE;
                mem_addr_d    = depth_q[ADDR_BITS-1:0];
                mem_data_in_d = cmd_data;
                depth_d       = depth_q + DEPTH_ONE;
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty_q) begin
                state_d    = ST_RESP;
                rsp_err_d  = 1'b1;
                rsp_data_d = 4'h0;
              end else begin
                state_d    = ST_READ;
                mem_mode_d = MODE_READ;
                mem_addr_d = depth_dec[ADDR_BITS-1:0];
                if (cmd_op == OP_POP) begin
                  depth_d = depth_dec;
                end else begin
                  depth_d = depth_q;
                end
              end
            end
            OP_CLEAR: begin
              // WRITE is reused as the pad cycle; a zeroed data_in makes it answer 0.
              state_d       = ST_WRITE;
              mem_mode_d    = MODE_CLEAR;
              mem_data_in_d = 4'h0;
              depth_d       = DEPTH_ZERO;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d    = ST_RESP;
        rsp_data_d = mem_data_in_q;
        rsp_err_d  = 1'b0;
      end
      ST_READ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d    = ST_RESP;
        rsp_data_d = mem_data_out;
        rsp_err_d  = 1'b0;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    full_d  = (depth_d == DEPTH_MAX);
    empty_d = (depth_d == DEPTH_ZERO);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      depth_q       <= DEPTH_ZERO;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 4'h0;
      rsp_err_q     <= 1'b0;
      mem_mode_q    <= MODE_IDLE;
      mem_addr_q    <= '0;
      mem_data_in_q <= 4'h0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      mem_mode_q    <= mem_mode_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign depth       = depth_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign mem_mode    = mem_mode_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: behavioural 16x4 memory, table-driven commands,
// response scoreboard with latency checks, plus full/overflow and reset-abort sequences.

`ifndef MEMORY_MODE_IDLE
`define MEMORY_MODE_IDLE 2'b00
`endif
`ifndef MEMORY_MODE_READ
`define MEMORY_MODE_READ 2'b01
`endif
`ifndef MEMORY_MODE_WRITE
`define MEMORY_MODE_WRITE 2'b10
`endif
`ifndef MEMORY_MODE_CLEAR
`define MEMORY_MODE_CLEAR 2'b11
`endif

module tb_stack_ctrl;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] PEEK = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;
  localparam logic [1:0] M_IDLE  = `MEMORY_MODE_IDLE;
  localparam logic [1:0] M_READ  = `MEMORY_MODE_READ;
  localparam logic [1:0] M_WRITE = `MEMORY_MODE_WRITE;
  localparam logic [1:0] M_CLEAR = `MEMORY_MODE_CLEAR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [4:0] depth;
  logic       full;
  logic       empty;
  logic [1:0] mem_mode;
  logic [3:0] mem_addr;
  logic [3:0] mem_data_in;
  logic [3:0] mem_data_out;

  stack_ctrl #(.ADDR_BITS(4), .STACK_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .depth(depth), .full(full), .empty(empty),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, synchronous write and clear.
  logic [3:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'hE;
    mem_data_out = 4'h0;
  end
  always @(posedge clk) begin
    case (mem_mode)
      M_WRITE: mem[mem_addr] <= mem_data_in;
      M_READ:  mem_data_out <= mem[mem_addr];
      M_CLEAR: begin
        for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
        mem_data_out <= 4'h0;
      end
      default: ;
    endcase
  end

  int cyc = 0;
  int n_write = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && mem_mode == M_WRITE) n_write <= n_write + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] d;
    logic       e;
    int         due;
    logic [4:0] dep;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Response monitor: every rsp_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.d));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.e));
        chk("rsp_latency", 32'(cyc), 32'(mon_e.due));
        chk("rsp_depth", 32'(depth), 32'(mon_e.dep));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [3:0] ed,
                      input logic ee, input int lat, input logic [4:0] edep);
    int t;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 32'd1, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{ed, ee, cyc + lat, edep});
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 4'($urandom);
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("rsp_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_init();
    int n;
    int t;
    n = 0;
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      if (mem_mode == M_CLEAR) n++;
      t++;
    end
    chk("init_clear_cycles", 32'(n), 32'd1);
    chk("init_ready", 32'(cmd_ready), 32'd1);
    chk("init_depth", 32'(depth), 32'd0);
    chk("init_empty", 32'(empty), 32'd1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] d;
    logic [3:0] ed;
    logic       ee;
    int         lat;
    logic [4:0] dep;
  } vec_t;
  vec_t tbl[17];

  function automatic vec_t mk(logic [1:0] op, logic [3:0] d, logic [3:0] ed, logic ee,
                              int lat, logic [4:0] dep);
    vec_t v;
    v.op = op; v.d = d; v.ed = ed; v.ee = ee; v.lat = lat; v.dep = dep;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    tbl[0]  = mk(PUSH, 4'h3, 4'h3, 1'b0, 2, 5'd1);
    tbl[1]  = mk(PUSH, 4'h7, 4'h7, 1'b0, 2, 5'd2);
    tbl[2]  = mk(PUSH, 4'hA, 4'hA, 1'b0, 2, 5'd3);
    tbl[3]  = mk(POP,  4'h0, 4'hA, 1'b0, 3, 5'd2);
    tbl[4]  = mk(POP,  4'h0, 4'h7, 1'b0, 3, 5'd1);
    tbl[5]  = mk(POP,  4'h0, 4'h3, 1'b0, 3, 5'd0);
    tbl[6]  = mk(POP,  4'h0, 4'h0, 1'b1, 1, 5'd0);
    tbl[7]  = mk(PEEK, 4'h0, 4'h0, 1'b1, 1, 5'd0);
    tbl[8]  = mk(PUSH, 4'h5, 4'h5, 1'b0, 2, 5'd1);
    tbl[9]  = mk(PEEK, 4'h0, 4'h5, 1'b0, 3, 5'd1);
    tbl[10] = mk(POP,  4'h0, 4'h5, 1'b0, 3, 5'd0);
    tbl[11] = mk(PUSH, 4'h9, 4'h9, 1'b0, 2, 5'd1);
    tbl[12] = mk(CLR,  4'hF, 4'h0, 1'b0, 2, 5'd0);
    tbl[13] = mk(POP,  4'h0, 4'h0, 1'b1, 1, 5'd0);
    tbl[14] = mk(PUSH, 4'hC, 4'hC, 1'b0, 2, 5'd1);
    tbl[15] = mk(PEEK, 4'h0, 4'hC, 1'b0, 3, 5'd1);
    tbl[16] = mk(POP,  4'h0, 4'hC, 1'b0, 3, 5'd0);

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_mem_mode", 32'(mem_mode), 32'(M_IDLE));
    chk("rst_depth", 32'(depth), 32'd0);
    rst_n = 1'b1;
    wait_init();
    chk("init_mem_cleared", 32'(mem[7]), 32'd0);

    for (int i = 0; i < 17; i++) begin
      send(tbl[i].op, tbl[i].d, tbl[i].ed, tbl[i].ee, tbl[i].lat, tbl[i].dep);
      if (tbl[i].op == CLR) chk("clear_mem0", 32'(mem[0]), 32'd0);
    end

    // Fill to the top, then overflow must not touch memory.
    for (int i = 0; i < 16; i++) send(PUSH, 4'(i), 4'(i), 1'b0, 2, 5'(i + 1));
    chk("full_flag", 32'(full), 32'd1);
    chk("full_depth", 32'(depth), 32'd16);
    chk("full_mem15", 32'(mem[15]), 32'hF);
    w = n_write;
    send(PUSH, 4'h1, 4'h0, 1'b1, 1, 5'd16);
    chk("overflow_no_write", 32'(n_write), 32'(w));
    for (int i = 15; i >= 0; i--) send(POP, 4'h0, 4'(i), 1'b0, 3, 5'(i));
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_full", 32'(full), 32'd0);

    // Reset while a POP sits in WAIT: no response, depth cleared, INIT clear repeated.
    send(PUSH, 4'h6, 4'h6, 1'b0, 2, 5'd1);
    cmd_valid = 1'b1;
    cmd_op    = POP;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_depth", 32'(depth), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    send(POP, 4'h0, 4'h0, 1'b1, 1, 5'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
